// File: rtl/i2c_fifo_pair_if.sv
// Bundles the host-side and I2C-master-side FIFO signals of i2c_fifo_pair.
// slave is the FIFO pair itself; master is whoever drives the host and master strobes.
interface i2c_fifo_pair_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
);
  // Host side
  logic                     tx_wr;
  logic [WIDTH-1:0]         tx_din;
  logic                     rx_rd;
  logic [WIDTH-1:0]         rx_dout;
  logic                     tx_clr;
  logic                     rx_clr;
  logic                     flag_clr;
  logic                     tx_full;
  logic                     rx_empty;
  logic [$clog2(DEPTH):0]   tx_level;
  logic [$clog2(DEPTH):0]   rx_level;
  logic                     tx_ovf;
  logic                     rx_ovf;
  logic                     rx_udf;
  // I2C master side
  logic                     mi_txff_rd;
  logic [WIDTH-1:0]         mi_txff_data;
  logic                     mi_txff_empty;
  logic                     mi_rxff_wr;
  logic [WIDTH-1:0]         mi_rxff_data;
  logic                     mi_rxff_full;

  modport slave (
    input  tx_wr, tx_din, rx_rd, tx_clr, rx_clr, flag_clr, mi_txff_rd, mi_rxff_wr, mi_rxff_data,
    output rx_dout, tx_full, rx_empty, tx_level, rx_level, tx_ovf, rx_ovf, rx_udf,
    output mi_txff_data, mi_txff_empty, mi_rxff_full
  );

  modport master (
    output tx_wr, tx_din, rx_rd, tx_clr, rx_clr, flag_clr, mi_txff_rd, mi_rxff_wr, mi_rxff_data,
    input  rx_dout, tx_full, rx_empty, tx_level, rx_level, tx_ovf, rx_ovf, rx_udf,
    input  mi_txff_data, mi_txff_empty, mi_rxff_full
  );
endinterface

// File: rtl/i2c_fifo_pair.sv
// TX (host -> I2C master) and RX (I2C master -> host) first-word-fall-through FIFOs
// with occupancy counts and sticky overflow/underflow flags.
module i2c_fifo_pair #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  i2c_fifo_pair_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [WIDTH-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [LW-1:0]    tx_level_q, tx_level_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;

  logic [WIDTH-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0]    rx_level_q, rx_level_d;
  logic             rx_ovf_q, rx_ovf_d, rx_udf_q, rx_udf_d;
  logic             rx_full, rx_empty, rx_push, rx_pop;

  // Status comes from the level register, so a push never bypasses to the head in-cycle.
  assign tx_full  = (tx_level_q == LevelFull);
  assign tx_empty = (tx_level_q == '0);
  assign tx_push  = bus.tx_wr & ~tx_full;
  assign tx_pop   = bus.mi_txff_rd & ~tx_empty;

  assign rx_full  = (rx_level_q == LevelFull);
  assign rx_empty = (rx_level_q == '0);
  assign rx_push  = bus.mi_rxff_wr & ~rx_full;
  assign rx_pop   = bus.rx_rd & ~rx_empty;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    if (bus.tx_clr) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_level_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
      if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LW'(1);
      else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LW'(1);
    end
    // A new error event beats flag_clr in the same cycle.
    tx_ovf_d = (tx_ovf_q & ~bus.flag_clr) | (bus.tx_wr & tx_full);
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_level_d  = rx_level_q;
    if (bus.rx_clr) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_level_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
      if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LW'(1);
      else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LW'(1);
    end
    rx_ovf_d = (rx_ovf_q & ~bus.flag_clr) | (bus.mi_rxff_wr & rx_full);
    rx_udf_d = (rx_udf_q & ~bus.flag_clr) | (bus.rx_rd & rx_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      tx_ovf_q    <= 1'b0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      rx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
      rx_ovf_q    <= rx_ovf_d;
      rx_udf_q    <= rx_udf_d;
    end
  end

  // Storage is never reset or flushed; only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && !bus.tx_clr && tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.tx_din;
    if (!rst && !bus.rx_clr && rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.mi_rxff_data;
  end

  assign bus.mi_txff_data  = tx_mem_q[tx_rd_ptr_q];
  assign bus.mi_txff_empty = tx_empty;
  assign bus.tx_full       = tx_full;
  assign bus.tx_level      = tx_level_q;
  assign bus.tx_ovf        = tx_ovf_q;

  assign bus.rx_dout       = rx_mem_q[rx_rd_ptr_q];
  assign bus.rx_empty      = rx_empty;
  assign bus.mi_rxff_full  = rx_full;
  assign bus.rx_level      = rx_level_q;
  assign bus.rx_ovf        = rx_ovf_q;
  assign bus.rx_udf        = rx_udf_q;
endmodule

// File: tb/tb_i2c_fifo_pair.sv
// Directed bench for i2c_fifo_pair: a per-cycle vector table plus hand sequences for
// fill/drain, simultaneous push/pop, clear and reset corner cases.
module tb_i2c_fifo_pair;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  i2c_fifo_pair_if #(.DEPTH(16), .WIDTH(8)) bus ();

  i2c_fifo_pair #(.DEPTH(16), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, tx_wr;
    logic [7:0] tx_din;
    logic       txrd, rxrd, rxwr;
    logic [7:0] rx_data;
    logic       tx_clr, rx_clr, fclr;
    int         txl, rxl;
    logic       txe, rxe, txf, rxf, txo, rxo, udf;
    logic       txc;
    int         txd;
    logic       rxc;
    int         rxd;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.tx_wr = 1'b0; bus.mi_txff_rd = 1'b0; bus.rx_rd = 1'b0; bus.mi_rxff_wr = 1'b0;
    bus.tx_clr = 1'b0; bus.rx_clr = 1'b0; bus.flag_clr = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_wr = 1'b1; bus.tx_din = d;
  endtask

  task automatic push_rx(input logic [7:0] d);
    bus.mi_rxff_wr = 1'b1; bus.mi_rxff_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_wr = 1'b0; bus.tx_din = '0; bus.rx_rd = 1'b0; bus.tx_clr = 1'b0; bus.rx_clr = 1'b0;
    bus.flag_clr = 1'b0; bus.mi_txff_rd = 1'b0; bus.mi_rxff_wr = 1'b0; bus.mi_rxff_data = '0;

    //           rst wr din   trd rrd rwr rdat   tcl rcl fcl txl rxl txe rxe txf rxf txo rxo udf txc txd  rxc rxd
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[1]  = '{0, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'hA5, 0, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[4]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0,    0, 0};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[6]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0,    0, 0};
    vecs[7]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[8]  = '{0, 1, 8'h11, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h11, 0, 0};
    vecs[9]  = '{0, 1, 8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h11, 0, 0};
    vecs[10] = '{0, 1, 8'h33, 0, 0, 0, 8'h00, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h11, 0, 0};
    vecs[11] = '{0, 1, 8'h44, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[12] = '{0, 1, 8'h3C, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h3C, 0, 0};
    vecs[13] = '{0, 0, 8'h00, 0, 0, 1, 8'h5A, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h3C, 1, 'h5A};
    vecs[14] = '{0, 0, 8'h00, 1, 1, 1, 8'h6B, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,    1, 'h6B};
    vecs[15] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0};
    vecs[16] = '{0, 1, 8'h77, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h77, 0, 0};
    vecs[17] = '{0, 0, 8'h00, 0, 0, 1, 8'h88, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h77, 1, 'h88};
    vecs[18] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h77, 0, 0};

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      bus.tx_wr = vecs[i].tx_wr;       bus.tx_din = vecs[i].tx_din;
      bus.mi_txff_rd = vecs[i].txrd;   bus.rx_rd = vecs[i].rxrd;
      bus.mi_rxff_wr = vecs[i].rxwr;   bus.mi_rxff_data = vecs[i].rx_data;
      bus.tx_clr = vecs[i].tx_clr;     bus.rx_clr = vecs[i].rx_clr;
      bus.flag_clr = vecs[i].fclr;
      tick();
      chk($sformatf("v%0d tx_level", i), 32'(bus.tx_level), vecs[i].txl);
      chk($sformatf("v%0d rx_level", i), 32'(bus.rx_level), vecs[i].rxl);
      chk($sformatf("v%0d mi_txff_empty", i), 32'(bus.mi_txff_empty), 32'(vecs[i].txe));
      chk($sformatf("v%0d rx_empty", i), 32'(bus.rx_empty), 32'(vecs[i].rxe));
      chk($sformatf("v%0d tx_full", i), 32'(bus.tx_full), 32'(vecs[i].txf));
      chk($sformatf("v%0d mi_rxff_full", i), 32'(bus.mi_rxff_full), 32'(vecs[i].rxf));
      chk($sformatf("v%0d tx_ovf", i), 32'(bus.tx_ovf), 32'(vecs[i].txo));
      chk($sformatf("v%0d rx_ovf", i), 32'(bus.rx_ovf), 32'(vecs[i].rxo));
      chk($sformatf("v%0d rx_udf", i), 32'(bus.rx_udf), 32'(vecs[i].udf));
      if (vecs[i].txc) chk($sformatf("v%0d mi_txff_data", i), 32'(bus.mi_txff_data), vecs[i].txd);
      if (vecs[i].rxc) chk($sformatf("v%0d rx_dout", i), 32'(bus.rx_dout), vecs[i].rxd);
    end

    // TX fill past full, then drain in order.
    rst = 1'b1; tick();
    for (int i = 0; i < 17; i++) begin
      push_tx(8'(i)); tick();
      chk($sformatf("fill tx_level %0d", i), 32'(bus.tx_level), (i < 16) ? i + 1 : 16);
      chk($sformatf("fill tx_full %0d", i), 32'(bus.tx_full), (i >= 15) ? 1 : 0);
      chk($sformatf("fill tx_ovf %0d", i), 32'(bus.tx_ovf), (i == 16) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain tx data %0d", i), 32'(bus.mi_txff_data), i);
      bus.mi_txff_rd = 1'b1; tick();
    end
    chk("drain tx empty", 32'(bus.mi_txff_empty), 1);
    chk("drain tx level", 32'(bus.tx_level), 0);
    chk("drain tx ovf sticky", 32'(bus.tx_ovf), 1);

    // RX simultaneous push/pop with 5 queued, then full-with-push-and-pop.
    rst = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      push_rx(8'('h10 + i)); tick();
    end
    chk("rx5 level", 32'(bus.rx_level), 5);
    chk("rx5 head", 32'(bus.rx_dout), 'h10);
    push_rx(8'h15); bus.rx_rd = 1'b1; tick();
    chk("rx5 pushpop level", 32'(bus.rx_level), 5);
    chk("rx5 pushpop head", 32'(bus.rx_dout), 'h11);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rx5 order %0d", i), 32'(bus.rx_dout), 'h11 + i);
      bus.rx_rd = 1'b1; tick();
    end
    chk("rx5 empty", 32'(bus.rx_empty), 1);
    chk("rx5 no udf", 32'(bus.rx_udf), 0);
    for (int i = 0; i < 16; i++) begin
      push_rx(8'('h20 + i)); tick();
    end
    chk("rx full", 32'(bus.mi_rxff_full), 1);
    chk("rx full level", 32'(bus.rx_level), 16);
    chk("rx full no ovf", 32'(bus.rx_ovf), 0);
    push_rx(8'hFF); bus.rx_rd = 1'b1; tick();
    chk("rx full pushpop level", 32'(bus.rx_level), 15);
    chk("rx full pushpop ovf", 32'(bus.rx_ovf), 1);
    chk("rx full pushpop full", 32'(bus.mi_rxff_full), 0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("rx drain %0d", i), 32'(bus.rx_dout), 'h21 + i);
      bus.rx_rd = 1'b1; tick();
    end
    chk("rx drain empty", 32'(bus.rx_empty), 1);

    // Reset with 8 entries in each FIFO.
    for (int i = 0; i < 8; i++) begin
      push_tx(8'('h40 + i)); push_rx(8'('h50 + i)); tick();
    end
    chk("pre-rst tx level", 32'(bus.tx_level), 8);
    chk("pre-rst rx level", 32'(bus.rx_level), 8);
    rst = 1'b1; push_tx(8'h99); push_rx(8'h99); bus.rx_rd = 1'b1; tick();
    chk("rst tx level", 32'(bus.tx_level), 0);
    chk("rst rx level", 32'(bus.rx_level), 0);
    chk("rst tx empty", 32'(bus.mi_txff_empty), 1);
    chk("rst rx empty", 32'(bus.rx_empty), 1);
    chk("rst tx full", 32'(bus.tx_full), 0);
    chk("rst rx full", 32'(bus.mi_rxff_full), 0);
    chk("rst flags", 32'({bus.tx_ovf, bus.rx_ovf, bus.rx_udf}), 0);
    push_tx(8'h3C); push_rx(8'h3C); tick();
    chk("post-rst tx head", 32'(bus.mi_txff_data), 'h3C);
    chk("post-rst rx head", 32'(bus.rx_dout), 'h3C);
    chk("post-rst tx level", 32'(bus.tx_level), 1);
    chk("post-rst rx level", 32'(bus.rx_level), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_fifo_pair.md
I2C_FIFO_PAIR -- requirements
Module: i2c_fifo_pair

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning entries per FIFO; a power of two, minimum 2.
REQ-002 SHALL provide parameter WIDTH, default 8, meaning the byte width of each entry.
REQ-003 SHALL provide port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL provide port tx_wr, input, 1 bit, host push into the TX FIFO.
REQ-006 SHALL provide port tx_din, input, WIDTH bits, host TX write data.
REQ-007 SHALL provide port rx_rd, input, 1 bit, host pop from the RX FIFO.
REQ-008 SHALL provide port rx_dout, output, WIDTH bits, RX head entry (show-ahead).
REQ-009 SHALL provide port tx_clr / rx_clr, input, 1 bit each, flush the named FIFO.
REQ-010 SHALL provide port flag_clr, input, 1 bit, clears the sticky error flags.
REQ-011 SHALL provide port tx_full / rx_empty, output, 1 bit each, host-side status.
REQ-012 SHALL provide port tx_level / rx_level, output, $clog2(DEPTH)+1 bits each, occupancy counts.
REQ-013 SHALL provide port tx_ovf / rx_ovf / rx_udf, output, 1 bit each, sticky error flags.
REQ-014 SHALL provide port mi_txff_rd, input, 1 bit, master pop from the TX FIFO.
REQ-015 SHALL provide port mi_txff_data, output, WIDTH bits, TX head entry; drives the master data_in.
REQ-016 SHALL provide port mi_txff_empty, output, 1 bit, TX FIFO empty.
REQ-017 SHALL provide port mi_rxff_wr, input, 1 bit, master push into the RX FIFO.
REQ-018 SHALL provide port mi_rxff_data, input, WIDTH bits, received byte from the master data_out.
REQ-019 SHALL provide port mi_rxff_full, output, 1 bit, RX FIFO full.

Function
REQ-020 SHALL implement two independent circular FIFOs (TX: host to master, RX: master to host), each with wr_ptr, rd_ptr and level registers.
REQ-021 SHALL make each FIFO first-word-fall-through: mi_txff_data and rx_dout show mem[rd_ptr] combinationally in the same cycle, because the master samples data_in in the cycle mi_txff_rd is high.
REQ-022 SHALL accept a push iff the registered full flag is 0: entry written at wr_ptr, wr_ptr+1 modulo DEPTH; a push while full is dropped and sets ovf on the next edge.
REQ-023 SHALL accept a pop iff the registered empty flag is 0: rd_ptr+1 modulo DEPTH; a pop while empty is ignored; an RX pop while empty sets rx_udf. A TX pop while empty produces no flag, since the master gates it already.
REQ-024 SHALL update level +1 on an accepted push only, -1 on an accepted pop only, and leave it unchanged on both; level never exceeds DEPTH and never underflows.
REQ-025 SHALL allow push and pop in the same cycle on a FIFO that is neither full nor empty. When full, only the pop is accepted; when empty, only the push is accepted (no bypass).
REQ-026 SHALL derive full = (level==DEPTH) and empty = (level==0), each valid one cycle after the causing edge.
REQ-027 SHALL give tx_clr / rx_clr priority over any push or pop in the same cycle: pointers and level go to 0, and memory contents are not cleared.
REQ-028 SHALL keep error flags sticky until flag_clr; a new error event in the same cycle as flag_clr wins, so the flag stays 1.
REQ-029 SHALL add no latency beyond one cycle from push to data visible at the head of an empty FIFO.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set both FIFOs' pointers and levels to 0, force empty=1 and full=0, and clear all error flags; rst overrides every other input.
REQ-031 SHALL, after reset, present mi_txff_empty=1, rx_empty=1, tx_full=0, mi_rxff_full=0, levels=0, flags=0; the data outputs are don't-care while empty.
REQ-032 SHALL, on reset mid-transfer, discard queued bytes; the next push after reset lands at address 0.

Verification
REQ-033 Bench SHALL cover: push 0xA5 into TX -> next cycle mi_txff_empty=0, mi_txff_data=0xA5, tx_level=1; mi_txff_rd pulse -> empty=1, level=0.
REQ-034 Bench SHALL cover: 17 host pushes 0x00..0x10 (DEPTH=16) -> tx_full=1 after the 16th, tx_ovf=1, level=16; pops return 0x00..0x0F in order.
REQ-035 Bench SHALL cover: RX holding 5 entries, mi_rxff_wr and rx_rd in the same cycle -> rx_level stays 5 and the order is preserved.
REQ-036 Bench SHALL cover: rx_rd on an empty RX -> rx_udf=1; flag_clr -> 0; a second rx_rd together with flag_clr -> rx_udf remains 1.
REQ-037 Bench SHALL cover: TX holding 3 entries, tx_clr together with tx_wr -> tx_level=0 and mi_txff_empty=1.
REQ-038 Bench SHALL cover: rst asserted with 8 entries queued in each FIFO -> all levels 0 and empties 1; a push of 0x3C then appears at the head.
